// File: rtl/addsub_rr_if.sv
// Bundle of requester, add/sub-unit and response signals for the round-robin add/sub scheduler.
// The slave modport is the scheduler's view; master is the surrounding clients/unit.
interface addsub_rr_if #(
    parameter int W = 64,
    parameter int N = 4
);
    localparam int IDW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_mode;
    logic           au_valid;
    logic [W-1:0]   au_a;
    logic [W-1:0]   au_b;
    logic           au_mode;
    logic [W-1:0]   au_sum;
    logic           au_carry;
    logic           rsp_valid;
    logic [IDW-1:0] rsp_id;
    logic [W-1:0]   rsp_sum;
    logic           rsp_carry;
    logic           busy;
    logic [31:0]    op_count;

    modport slave (
        input  req_valid, req_a, req_b, req_mode, au_sum, au_carry,
        output req_ready, au_valid, au_a, au_b, au_mode,
               rsp_valid, rsp_id, rsp_sum, rsp_carry, busy, op_count
    );

    modport master (
        output req_valid, req_a, req_b, req_mode, au_sum, au_carry,
        input  req_ready, au_valid, au_a, au_b, au_mode,
               rsp_valid, rsp_id, rsp_sum, rsp_carry, busy, op_count
    );
endinterface

// File: rtl/addsub_rr_scheduler.sv
// Round-robin scheduler sharing one fixed-latency add/sub unit among N requesters;
// a LAT-deep tag pipe routes each result back to its owner as a one-cycle response.
module addsub_rr_scheduler #(
    parameter int W   = 64,
    parameter int N   = 4,
    parameter int LAT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    addsub_rr_if.slave   bus
);
    localparam int IDW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   pending_q, pending_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [31:0]    op_count_q, op_count_d;
    logic           au_valid_q;
    logic [W-1:0]   au_a_q, au_b_q;
    logic           au_mode_q;
    logic [IDW-1:0] au_id_q;
    logic [LAT-1:0] tag_vld_q;
    logic [IDW-1:0] tag_id_q [LAT];
    logic           rsp_valid_q;
    logic [IDW-1:0] rsp_id_q;
    logic [W-1:0]   rsp_sum_q;
    logic           rsp_carry_q;

    logic [N-1:0]   eligible_s;
    logic [N-1:0]   ready_s;
    logic           grant_vld_s;
    logic [IDW-1:0] grant_id_s;
    logic [IDW-1:0] rr_next_s;

    assign eligible_s = bus.req_valid & ~pending_q;

    // Cyclic priority search starting at rr_ptr: first eligible requester wins.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_id_s  = '0;
        for (int k = 0; k < N; k++) begin
            if (!grant_vld_s && eligible_s[(int'(rr_ptr_q) + k) % N]) begin
                grant_vld_s = 1'b1;
                grant_id_s  = IDW'((int'(rr_ptr_q) + k) % N);
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
        rr_next_s = IDW'((int'(grant_id_s) + 1) % N);
    end

    // One-hot ready decode of the current grant.
    always_comb begin
        ready_s = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_vld_s && (int'(grant_id_s) == i)) begin
                ready_s[i] = 1'b1;
            end else begin
                ready_s[i] = 1'b0;
            end
        end
    end

    // Next-state for pointer, pending flags and completion counter.
    always_comb begin
        pending_d  = pending_q;
        rr_ptr_d   = rr_ptr_q;
        op_count_d = op_count_q;
        // A returning tag frees its owner at the same edge its response is launched.
        if (tag_vld_q[LAT-1]) begin
            pending_d[tag_id_q[LAT-1]] = 1'b0;
            op_count_d                 = op_count_q + 32'd1;
        end else begin
            op_count_d = op_count_q;
        end
        if (grant_vld_s) begin
            pending_d[grant_id_s] = 1'b1;
            rr_ptr_d              = rr_next_s;
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // State, issue registers, tag pipe and response registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q   <= '0;
            rr_ptr_q    <= '0;
            op_count_q  <= 32'd0;
            au_valid_q  <= 1'b0;
            au_a_q      <= '0;
            au_b_q      <= '0;
            au_mode_q   <= 1'b0;
            au_id_q     <= '0;
            tag_vld_q   <= '0;
            for (int i = 0; i < LAT; i++) begin
                tag_id_q[i] <= '0;
            end
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_carry_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            rr_ptr_q   <= rr_ptr_d;
            op_count_q <= op_count_d;
            au_valid_q <= grant_vld_s;
            if (grant_vld_s) begin
                au_a_q    <= bus.req_a[int'(grant_id_s)*W +: W];
                au_b_q    <= bus.req_b[int'(grant_id_s)*W +: W];
                au_mode_q <= bus.req_mode[grant_id_s];
                au_id_q   <= grant_id_s;
            end
            tag_vld_q[0] <= au_valid_q;
            tag_id_q[0]  <= au_id_q;
            for (int i = 1; i < LAT; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_id_q[i]  <= tag_id_q[i-1];
            end
            rsp_valid_q <= tag_vld_q[LAT-1];
            if (tag_vld_q[LAT-1]) begin
                rsp_id_q    <= tag_id_q[LAT-1];
                rsp_sum_q   <= bus.au_sum;
                rsp_carry_q <= bus.au_carry;
            end
        end
    end

    assign bus.req_ready = ready_s;
    assign bus.au_valid  = au_valid_q;
    assign bus.au_a      = au_a_q;
    assign bus.au_b      = au_b_q;
    assign bus.au_mode   = au_mode_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.rsp_carry = rsp_carry_q;
    assign bus.busy      = |pending_q;
    assign bus.op_count  = op_count_q;
endmodule

// File: tb/tb_addsub_rr_scheduler.sv
// Directed bench for addsub_rr_scheduler with a behavioural LAT-cycle add/sub unit.
module tb_addsub_rr_scheduler;
    localparam int W   = 64;
    localparam int N   = 4;
    localparam int LAT = 2;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;
    int   exp_ops;

    addsub_rr_if #(.W(W), .N(N)) bus ();

    addsub_rr_scheduler #(.W(W), .N(N), .LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Add/sub unit model: a + (mode ? ~b : b) + mode, delayed LAT cycles.
    logic [W:0] unit_pipe [LAT];
    always @(posedge clk) begin
        unit_pipe[0] <= {1'b0, bus.au_a} + {1'b0, (bus.au_mode ? ~bus.au_b : bus.au_b)}
                        + {{W{1'b0}}, bus.au_mode};
        for (int i = 1; i < LAT; i++) begin
            unit_pipe[i] <= unit_pipe[i-1];
        end
    end
    assign bus.au_sum   = unit_pipe[LAT-1][W-1:0];
    assign bus.au_carry = unit_pipe[LAT-1][W];

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic set_req(input int idx, input logic [63:0] a, input logic [63:0] b, input logic m);
        bus.req_a[idx*W +: W] = a;
        bus.req_b[idx*W +: W] = b;
        bus.req_mode[idx]     = m;
    endtask

    // Single isolated op on an idle scheduler: checks issue, response and counter.
    task automatic do_op(input int idx, input logic [63:0] a, input logic [63:0] b, input logic m,
                         input logic [63:0] es, input logic ec);
        set_req(idx, a, b, m);
        bus.req_valid[idx] = 1'b1;
        #1;
        check_eq("op_ready", 64'(bus.req_ready), 64'd1 << idx);
        @(negedge clk);
        bus.req_valid[idx] = 1'b0;
        check_eq("op_au_valid", 64'(bus.au_valid), 64'd1);
        check_eq("op_au_a", bus.au_a, a);
        check_eq("op_au_b", bus.au_b, b);
        check_eq("op_au_mode", 64'(bus.au_mode), 64'(m));
        check_eq("op_busy", 64'(bus.busy), 64'd1);
        @(negedge clk);
        check_eq("op_au_valid_drop", 64'(bus.au_valid), 64'd0);
        @(negedge clk);
        check_eq("op_rsp_early", 64'(bus.rsp_valid), 64'd0);
        @(negedge clk);
        exp_ops++;
        check_eq("op_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check_eq("op_rsp_id", 64'(bus.rsp_id), 64'(idx));
        check_eq("op_rsp_sum", bus.rsp_sum, es);
        check_eq("op_rsp_carry", 64'(bus.rsp_carry), 64'(ec));
        check_eq("op_busy_clr", 64'(bus.busy), 64'd0);
        check_eq("op_count", 64'(bus.op_count), 64'(exp_ops));
        @(negedge clk);
        check_eq("op_rsp_pulse", 64'(bus.rsp_valid), 64'd0);
    endtask

    initial begin
        n_assert      = 0;
        n_fail        = 0;
        exp_ops       = 0;
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_mode  = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_au_valid", 64'(bus.au_valid), 64'd0);
        check_eq("rst_au_a", bus.au_a, 64'd0);
        check_eq("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check_eq("rst_busy", 64'(bus.busy), 64'd0);
        check_eq("rst_op_count", 64'(bus.op_count), 64'd0);
        check_eq("rst_ready", 64'(bus.req_ready), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single add, subtract with borrow, subtract without borrow.
        do_op(0, 64'd5, 64'd3, 1'b0, 64'd8, 1'b0);
        do_op(2, 64'd3, 64'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        do_op(2, 64'd5, 64'd3, 1'b1, 64'd2, 1'b1);

        // Pointer sits at 3: req3 wins over req0, then req0, pointer ends at 1.
        set_req(3, 64'd10, 64'd1, 1'b0);
        set_req(0, 64'd7, 64'd7, 1'b1);
        bus.req_valid = 4'b1001;
        #1;
        check_eq("wrap_ready3", 64'(bus.req_ready), 64'h8);
        @(negedge clk);
        check_eq("wrap_ready0", 64'(bus.req_ready), 64'h1);
        check_eq("wrap_au_a3", bus.au_a, 64'd10);
        bus.req_valid[3] = 1'b0;
        @(negedge clk);
        check_eq("wrap_au_a0", bus.au_a, 64'd7);
        check_eq("wrap_au_mode0", 64'(bus.au_mode), 64'd1);
        check_eq("wrap_ready_none", 64'(bus.req_ready), 64'd0);
        bus.req_valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("wrap_rsp_id3", 64'(bus.rsp_id), 64'd3);
        check_eq("wrap_rsp_sum3", bus.rsp_sum, 64'd11);
        @(negedge clk);
        check_eq("wrap_rsp_id0", 64'(bus.rsp_id), 64'd0);
        check_eq("wrap_rsp_sum0", bus.rsp_sum, 64'd0);
        check_eq("wrap_rsp_carry0", 64'(bus.rsp_carry), 64'd1);
        @(negedge clk);
        check_eq("wrap_rsp_end", 64'(bus.rsp_valid), 64'd0);
        check_eq("wrap_op_count", 64'(bus.op_count), 64'd5);
        set_req(2, 64'd1, 64'd1, 1'b0);
        bus.req_valid = 4'b0101;
        #1;
        check_eq("wrap_ptr1", 64'(bus.req_ready), 64'h4);
        @(negedge clk);
        bus.req_valid = '0;
        repeat (5) @(negedge clk);

        // All four requesters from reset: back-to-back issue, in-order responses.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            set_req(i, 64'(i + 1), 64'd1, 1'b0);
        end
        bus.req_valid = 4'b1111;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            check_eq("all_au_valid", 64'(bus.au_valid), (c <= 4) ? 64'd1 : 64'd0);
            if (c <= 4) begin
                check_eq("all_au_a", bus.au_a, 64'(c));
            end
            check_eq("all_rsp_valid", 64'(bus.rsp_valid), (c >= 4) ? 64'd1 : 64'd0);
            if (c >= 4) begin
                check_eq("all_rsp_id", 64'(bus.rsp_id), 64'(c - 4));
                check_eq("all_rsp_sum", bus.rsp_sum, 64'(c - 2));
                check_eq("all_regrant", 64'(bus.req_ready), 64'd1 << (c - 4));
                bus.req_valid[c-4] = 1'b0;
            end else begin
                check_eq("all_ready", 64'(bus.req_ready), 64'd1 << c);
            end
        end
        @(negedge clk);
        check_eq("all_rsp_end", 64'(bus.rsp_valid), 64'd0);
        check_eq("all_op_count", 64'(bus.op_count), 64'd4);
        check_eq("all_busy", 64'(bus.busy), 64'd0);

        // req1 keeps valid asserted: blocked until its response cycle.
        set_req(1, 64'd20, 64'd5, 1'b1);
        bus.req_valid = 4'b0010;
        #1;
        check_eq("hold_ready", 64'(bus.req_ready), 64'h2);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c < 4) begin
                check_eq("hold_blocked", 64'(bus.req_ready), 64'd0);
                check_eq("hold_busy", 64'(bus.busy), 64'd1);
                check_eq("hold_no_rsp", 64'(bus.rsp_valid), 64'd0);
            end else begin
                check_eq("hold_rsp_valid", 64'(bus.rsp_valid), 64'd1);
                check_eq("hold_rsp_id", 64'(bus.rsp_id), 64'd1);
                check_eq("hold_rsp_sum", bus.rsp_sum, 64'd15);
                check_eq("hold_rsp_carry", 64'(bus.rsp_carry), 64'd1);
                check_eq("hold_regrant", 64'(bus.req_ready), 64'h2);
                check_eq("hold_busy_clr", 64'(bus.busy), 64'd0);
            end
        end
        bus.req_valid = '0;
        @(negedge clk);
        check_eq("hold_op_count", 64'(bus.op_count), 64'd5);

        // Reset with two ops in flight: their results are dropped.
        set_req(0, 64'd1, 64'd2, 1'b0);
        set_req(1, 64'd3, 64'd4, 1'b0);
        bus.req_valid = 4'b0011;
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        @(negedge clk);
        bus.req_valid = '0;
        check_eq("mid_busy_pre", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("mid_busy", 64'(bus.busy), 64'd0);
        check_eq("mid_op_count", 64'(bus.op_count), 64'd0);
        check_eq("mid_au_valid", 64'(bus.au_valid), 64'd0);
        for (int c = 0; c < 6; c++) begin
            check_eq("mid_no_rsp", 64'(bus.rsp_valid), 64'd0);
            @(negedge clk);
        end
        set_req(1, 64'd9, 64'd9, 1'b0);
        bus.req_valid = 4'b1010;
        #1;
        check_eq("mid_ptr0", 64'(bus.req_ready), 64'h2);
        @(negedge clk);
        bus.req_valid = '0;
        check_eq("mid_au_a", bus.au_a, 64'd9);
        repeat (3) @(negedge clk);
        check_eq("mid_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check_eq("mid_rsp_id", 64'(bus.rsp_id), 64'd1);
        check_eq("mid_rsp_sum", bus.rsp_sum, 64'd18);
        check_eq("mid_op_count_after", 64'(bus.op_count), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
